// File: rtl/memory_responder.sv
// Single-port memory responder with programmable wait states and a one-cycle ready pulse.
// Optional write protection of the low WP_TOP words is enabled with `define MEM_WP_EN.
module memory_responder #(
  parameter int ADDR_WIDTH  = 13,
  parameter int DATA_WIDTH  = 8,
  parameter int DEPTH       = 8192,
  parameter int WAIT_STATES = 2
`ifdef MEM_WP_EN
  , parameter int WP_TOP    = 64
`endif
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] address,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic                  mem_read,
  input  logic                  mem_write,
  output logic [DATA_WIDTH-1:0] command,
  output logic                  mem_ready,
  output logic                  mem_busy,
  output logic                  wr_fault
);

  localparam int IDX_W = $clog2(DEPTH);

  typedef enum logic [1:0] {
    S_IDLE,
    S_WAIT,
    S_RESP
  } state_t;

  state_t                state_q, state_d;
  logic [3:0]            cnt_q, cnt_d;
  logic [IDX_W-1:0]      addr_q, addr_d;
  logic [DATA_WIDTH-1:0] data_q, data_d;
  logic                  wr_q, wr_d;
  logic [DATA_WIDTH-1:0] cmd_q, cmd_d;

  logic                  acc;
  logic                  acc_wr;
  logic [IDX_W-1:0]      acc_addr;
  logic [DATA_WIDTH-1:0] acc_data;
  logic                  prot;
  logic                  mem_we;
  logic                  unused_addr;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  assign unused_addr = ^address;

  // acc marks the edge that enters RESP; with zero wait states that is the capture edge
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    addr_d   = addr_q;
    data_d   = data_q;
    wr_d     = wr_q;
    cmd_d    = cmd_q;
    acc      = 1'b0;
    acc_wr   = wr_q;
    acc_addr = addr_q;
    acc_data = data_q;
    unique case (state_q)
      S_IDLE: begin
        if (mem_read || mem_write) begin
          addr_d = address[IDX_W-1:0];
          data_d = write_data;
          wr_d   = mem_write;
          if (WAIT_STATES == 0) begin
            state_d  = S_RESP;
            acc      = 1'b1;
            acc_wr   = mem_write;
            acc_addr = address[IDX_W-1:0];
            acc_data = write_data;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_STATES);
          end
        end
      end
      S_WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) begin
          state_d = S_RESP;
          acc     = 1'b1;
        end
      end
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (acc && !acc_wr) cmd_d = mem[acc_addr];
  end

`ifdef MEM_WP_EN
  localparam int WP_LIM = (WP_TOP < DEPTH) ? WP_TOP : DEPTH;

  logic fault_q, fault_d;

  assign prot    = ({1'b0, acc_addr} < (IDX_W+1)'(WP_LIM));
  assign fault_d = acc && acc_wr && prot;
  assign wr_fault = fault_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) fault_q <= 1'b0;
    else     fault_q <= fault_d;
  end
`else
  assign prot     = 1'b0;
  assign wr_fault = 1'b0;
`endif

  assign mem_we = acc && acc_wr && !prot;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      data_q  <= '0;
      wr_q    <= 1'b0;
      cmd_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      wr_q    <= wr_d;
      cmd_q   <= cmd_d;
    end
  end

  // Array has no reset; a write is dropped if rst is high at its edge
  always_ff @(posedge clk) begin
    if (mem_we && !rst) mem[acc_addr] <= acc_data;
  end

  assign command   = cmd_q;
  assign mem_ready = (state_q == S_RESP);
  assign mem_busy  = (state_q != S_IDLE);

endmodule

// File: tb/tb_memory_responder.sv
// Bench for memory_responder: u0 has 2 wait states / 8192 words,
// u1 has 0 wait states / 4096 words; both are checked against a transaction-level model.
module tb_memory_responder;

  logic        clk;
  logic        rst;
  logic [12:0] addr_i [2];
  logic [7:0]  wd_i   [2];
  logic        rd_i   [2];
  logic        wr_i   [2];
  logic [7:0]  cmd_o  [2];
  logic        rdy_o  [2];
  logic        busy_o [2];
  logic        flt_o  [2];

  int n_chk;
  int n_fail;

  logic [7:0] mmem [2][int];
  logic [7:0] mcmd [2];
  bit         mknown [2];

`ifdef MEM_WP_EN
  localparam bit WP = 1'b1;
  localparam logic [12:0] A_BOTH = 13'h0050;
  localparam logic [12:0] A_RST  = 13'h0060;
`else
  localparam bit WP = 1'b0;
  localparam logic [12:0] A_BOTH = 13'h0010;
  localparam logic [12:0] A_RST  = 13'h0020;
`endif

  memory_responder #(.DEPTH(8192), .WAIT_STATES(2)) u0 (
    .clk(clk), .rst(rst), .address(addr_i[0]), .write_data(wd_i[0]),
    .mem_read(rd_i[0]), .mem_write(wr_i[0]), .command(cmd_o[0]),
    .mem_ready(rdy_o[0]), .mem_busy(busy_o[0]), .wr_fault(flt_o[0])
  );

  memory_responder #(.DEPTH(4096), .WAIT_STATES(0)) u1 (
    .clk(clk), .rst(rst), .address(addr_i[1]), .write_data(wd_i[1]),
    .mem_read(rd_i[1]), .mem_write(wr_i[1]), .command(cmd_o[1]),
    .mem_ready(rdy_o[1]), .mem_busy(busy_o[1]), .wr_fault(flt_o[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int ws(input int d);
    return (d == 0) ? 2 : 0;
  endfunction

  function automatic int dep(input int d);
    return (d == 0) ? 8192 : 4096;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One full request/response; checks latency, pulse widths and the model
  task automatic txn(input int d, input logic w, input logic r,
                     input logic [12:0] a, input logic [7:0] wd);
    int key, first, pulses, busyc, fcnt, fcoin;
    bit pr;
    key = int'(a) % dep(d);
    pr  = w && WP && (key < 64);
    rd_i[d] = r; wr_i[d] = w; addr_i[d] = a; wd_i[d] = wd;
    tick();
    rd_i[d] = 1'b0; wr_i[d] = 1'b0;
    first = -1; pulses = 0; busyc = 0; fcnt = 0; fcoin = 0;
    for (int k = 0; k < 40; k++) begin
      if (k > 0) tick();
      addr_i[d] = 13'($urandom);
      wd_i[d]   = 8'($urandom);
      if (rdy_o[d]) begin
        pulses++;
        if (first < 0) first = k;
      end
      if (flt_o[d]) fcnt++;
      if (flt_o[d] && rdy_o[d]) fcoin++;
      if (busy_o[d]) busyc++;
      if (!busy_o[d]) break;
    end
    chk("latency", first, ws(d));
    chk("ready_pulses", pulses, 1);
    chk("busy_cycles", busyc, ws(d) + 1);
    chk("fault_cycles", fcnt, int'(pr));
    chk("fault_with_ready", fcoin, int'(pr));
    if (w) begin
      if (!pr) mmem[d][key] = wd;
    end else if (mmem[d].exists(key)) begin
      mcmd[d] = mmem[d][key];
      mknown[d] = 1'b1;
    end else begin
      mknown[d] = 1'b0;
    end
    if (mknown[d]) chk("command_model", cmd_o[d], mcmd[d]);
  endtask

  typedef struct {
    int          d;
    logic        w;
    logic        r;
    logic [12:0] a;
    logic [7:0]  wd;
    logic [7:0]  exp_cmd;
  } vec_t;

  vec_t vt [9];
  logic [7:0] base;
  logic [7:0] wpv;
  int rcnt;

  initial begin
    n_chk = 0; n_fail = 0;
    for (int d = 0; d < 2; d++) begin
      addr_i[d] = '0; wd_i[d] = '0; rd_i[d] = 1'b0; wr_i[d] = 1'b0;
      mcmd[d] = 8'h00; mknown[d] = 1'b1;
    end

    vt[0] = '{0, 1'b1, 1'b0, 13'h0100, 8'hA5, 8'h00};
    vt[1] = '{0, 1'b0, 1'b1, 13'h0100, 8'h00, 8'hA5};
    vt[2] = '{0, 1'b1, 1'b1, A_BOTH,   8'h3C, 8'hA5};
    vt[3] = '{0, 1'b0, 1'b1, A_BOTH,   8'h00, 8'h3C};
    vt[4] = '{1, 1'b1, 1'b0, 13'h1003, 8'h77, 8'h00};
    vt[5] = '{1, 1'b0, 1'b1, 13'h0003, 8'h00, 8'h77};
    vt[6] = '{1, 1'b1, 1'b0, 13'h0005, 8'h11, 8'h77};
    vt[7] = '{1, 1'b1, 1'b0, 13'h0006, 8'h22, 8'h77};
    vt[8] = '{0, 1'b1, 1'b0, A_RST,    8'h00, 8'h3C};

    rst = 1'b1;
    tick(); tick();
    for (int d = 0; d < 2; d++) begin
      chk("reset_command", cmd_o[d], 8'h00);
      chk("reset_ready", rdy_o[d], 1'b0);
      chk("reset_busy", busy_o[d], 1'b0);
      chk("reset_fault", flt_o[d], 1'b0);
    end
    rst = 1'b0;
    tick();

    for (int i = 0; i < 9; i++) begin
      txn(vt[i].d, vt[i].w, vt[i].r, vt[i].a, vt[i].wd);
      chk($sformatf("vec%0d_command", i), cmd_o[vt[i].d], vt[i].exp_cmd);
    end

    // zero-wait back-to-back reads with a held request
    rd_i[1] = 1'b1; addr_i[1] = 13'h0005;
    tick();
    chk("b2b_ready0", rdy_o[1], 1'b1);
    chk("b2b_cmd0", cmd_o[1], 8'h11);
    addr_i[1] = 13'h0006;
    tick();
    chk("b2b_gap_ready", rdy_o[1], 1'b0);
    chk("b2b_gap_busy", busy_o[1], 1'b0);
    tick();
    chk("b2b_ready1", rdy_o[1], 1'b1);
    chk("b2b_cmd1", cmd_o[1], 8'h22);
    rd_i[1] = 1'b0;
    tick();
    chk("b2b_end_ready", rdy_o[1], 1'b0);
    mcmd[1] = 8'h22;

    // reset in the middle of a write
    wr_i[0] = 1'b1; addr_i[0] = A_RST; wd_i[0] = 8'hFF;
    tick();
    wr_i[0] = 1'b0;
    chk("rst_pre_busy", busy_o[0], 1'b1);
    rst = 1'b1;
    #1;
    chk("rst_async_busy", busy_o[0], 1'b0);
    chk("rst_async_ready", rdy_o[0], 1'b0);
    chk("rst_async_cmd", cmd_o[0], 8'h00);
    tick();
    rst = 1'b0;
    mcmd[0] = 8'h00; mcmd[1] = 8'h00;
    mknown[0] = 1'b1; mknown[1] = 1'b1;
    rcnt = 0;
    for (int k = 0; k < 6; k++) begin
      tick();
      if (rdy_o[0]) rcnt++;
    end
    chk("rst_no_ready", rcnt, 0);
    txn(0, 1'b0, 1'b1, A_RST, 8'h00);
    chk("rst_array_kept", cmd_o[0], 8'h00);

`ifdef MEM_WP_EN
    txn(0, 1'b0, 1'b1, 13'h003F, 8'h00);
    base = cmd_o[0];
    wpv = (base == 8'h99) ? 8'h66 : 8'h99;
    txn(0, 1'b1, 1'b0, 13'h003F, wpv);
    txn(0, 1'b0, 1'b1, 13'h003F, 8'h00);
    chk("wp_unchanged", cmd_o[0], base);
    txn(0, 1'b1, 1'b0, 13'h0040, 8'h99);
    txn(0, 1'b0, 1'b1, 13'h0040, 8'h00);
    chk("wp_open", cmd_o[0], 8'h99);
`endif

    // randomized traffic over a preloaded pool, with aliasing on u1
    for (int d = 0; d < 2; d++)
      for (int i = 0; i < 16; i++)
        txn(d, 1'b1, 1'b0, 13'(13'h080 + i), 8'($urandom));
    for (int n = 0; n < 80; n++) begin
      int d, op, gap;
      logic [12:0] a;
      d  = int'($urandom_range(0, 1));
      op = int'($urandom_range(0, 2));
      a  = 13'(13'h080 + $urandom_range(0, 15));
      if (d == 1 && $urandom_range(0, 1) == 1) a[12] = 1'b1;
      txn(d, op != 1, op != 0, a, 8'($urandom));
      gap = int'($urandom_range(0, 2));
      for (int g = 0; g < gap; g++) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
